flipdot_scan_sequencer: RTL

Parametrised row/column scan sequencer for a bistable dot matrix driven by half-bridge drivers. It holds a double-buffered ROWS×COLS image and, on trigger, visits every dot in row-major order. For each dot it applies a break-before-make dead-time, then a set or reset pulse through one row driver and one column driver. It sits between the SPI command decoder (image writes, timing configuration) and the half-bridge driver pins, and it generalises the fixed 5×5 one-shot sequencer with arbitrary geometry, atomic image commit, abort and optional continuous looping.

---
 rtl/flipdot_scan_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/flipdot_scan_sequencer.sv
// Row/column scan sequencer for a bistable dot matrix with double-buffered image,
// break-before-make dead time and abort. Define FLIPDOT_SEQ_LOOP_EN for continuous looping.
module flipdot_scan_sequencer #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int CNT_W = 16,
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CNT_W-1:0]     cfg_ccr0,
  input  logic [CNT_W-1:0]     cfg_ccr1,
  input  logic [ROWS+COLS-1:0] cfg_invert,
  input  logic                 wr_en,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [COLS-1:0]      wr_data,
  input  logic                 commit,
  input  logic                 trigger,
  input  logic                 abort,
`ifdef FLIPDOT_SEQ_LOOP_EN
  input  logic                 loop_en,
`endif
  output logic                 busy,
  output logic                 frame_done,
  output logic [ROWS+COLS-1:0] drv_p,
  output logic [ROWS+COLS-1:0] drv_n,
  output logic [ROW_W-1:0]     cur_row,
  output logic [COL_W-1:0]     cur_col
);

  localparam int DRV = ROWS + COLS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DEAD  = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // A zero pulse width behaves as one cycle; the timer runs from width-1 down to 0.
  function automatic logic [CNT_W-1:0] pulse_load(input logic [CNT_W-1:0] width);
    return (width == '0) ? '0 : width - CNT_W'(1);
  endfunction

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [CNT_W-1:0]     ccr0_q, ccr0_d;
  logic [CNT_W-1:0]     ccr1_q, ccr1_d;
  logic [DRV-1:0]       inv_q, inv_d;
  logic [ROWS*COLS-1:0] shadow_q, shadow_d;
  logic [ROWS*COLS-1:0] active_q, active_d;
  logic                 pending_q, pending_d;
  logic                 trig_q;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DRV-1:0]       drv_p_q, drv_p_d;
  logic [DRV-1:0]       drv_n_q, drv_n_d;

  logic trig_rise;
  logic last_dot;
  logic dot_v;
  logic do_copy;

  always_comb begin
    trig_rise = trigger & ~trig_q;
    shadow_d  = shadow_q;
    if (wr_en) begin
      for (int r = 0; r < ROWS; r++) begin
        if (wr_row == ROW_W'(r)) shadow_d[r*COLS +: COLS] = wr_data;
      end
    end
  end

  always_comb begin
    dot_v = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (row_q == ROW_W'(r) && col_q == COL_W'(c)) dot_v = active_q[r*COLS + c];
      end
    end
    last_dot = (row_q == ROW_W'(ROWS-1)) && (col_q == COL_W'(COLS-1));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    ccr0_d    = ccr0_q;
    ccr1_d    = ccr1_q;
    inv_d     = inv_q;
    active_d  = active_q;
    pending_d = pending_q;
    do_copy   = 1'b0;

    // Image commit: immediate when idle, deferred to DONE while a frame is running.
    if (state_q == S_IDLE) begin
      do_copy = commit;
    end else if (state_q == S_DONE && !abort) begin
      do_copy = pending_q | commit;
    end else if (commit) begin
      pending_d = 1'b1;
    end
    if (do_copy) begin
      active_d  = shadow_d;
      pending_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          state_d = S_DEAD;
          row_d   = '0;
          col_d   = '0;
          ccr0_d  = cfg_ccr0;
          ccr1_d  = cfg_ccr1;
          inv_d   = cfg_invert;
          cnt_d   = cfg_ccr0;
        end
      end
      S_DEAD: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = pulse_load(ccr1_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (last_dot) begin
          state_d = S_DONE;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = S_DEAD;
          cnt_d   = ccr0_q;
          if (col_q == COL_W'(COLS-1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
`ifdef FLIPDOT_SEQ_LOOP_EN
        if (loop_en) begin
          state_d = S_DEAD;
          row_d   = '0;
          col_d   = '0;
          ccr0_d  = cfg_ccr0;
          ccr1_d  = cfg_ccr1;
          inv_d   = cfg_invert;
          cnt_d   = cfg_ccr0;
        end
`endif
      end
    endcase

    if (abort) state_d = S_IDLE;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    drv_p_d = '0;
    drv_n_d = '0;
    if (state_d == S_PULSE) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_q == ROW_W'(r)) begin
          drv_p_d[r] = dot_v ^ inv_q[r];
          drv_n_d[r] = ~(dot_v ^ inv_q[r]);
        end
      end
      for (int c = 0; c < COLS; c++) begin
        if (col_q == COL_W'(c)) begin
          drv_p_d[ROWS+c] = ~(dot_v ^ inv_q[ROWS+c]);
          drv_n_d[ROWS+c] = dot_v ^ inv_q[ROWS+c];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ccr0_q    <= '0;
      ccr1_q    <= '0;
      inv_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drv_p_q   <= '0;
      drv_n_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ccr0_q    <= ccr0_d;
      ccr1_q    <= ccr1_d;
      inv_q     <= inv_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      trig_q    <= trigger;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drv_p_q   <= drv_p_d;
      drv_n_q   <= drv_n_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign drv_p      = drv_p_q;
  assign drv_n      = drv_n_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;

endmodule
